ntt_uart_loader: RTL and testbench

Receive-side front end for the 16-point NTT demo. Deserialises 8N1 UART from the PC and parses one ASCII text line of 16 decimal coefficients into a staged coefficient vector. Commits the vector atomically, with a one-cycle strobe, so the top level can load the NTT input and start a computation. Complements the existing result-transmit path: results go out over `uart_tx`, coefficients come in over `uart_rx`.

---
 rtl/ntt_pkg.sv | 36 +++
 rtl/ntt_uart_loader_if.sv | 29 ++
 rtl/uart_rx.sv | 127 ++++++++++++
 rtl/ntt_uart_loader.sv | 176 +++++++++++++++++
 tb/tb_ntt_uart_loader.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT demo UART loader: vector geometry,
// modulus, ASCII byte codes, FSM state encodings and the mod-Q helper.
package ntt_pkg;

    localparam int N  = 16;
    localparam int Q  = 97;
    localparam int CW = 7;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_COMMA = 8'h2C;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    typedef enum logic [1:0] {
        P_IDLE,
        P_NUM,
        P_SEP,
        P_DISCARD
    } parse_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Constant-modulus reduction of a parsed value (max 999) into 0..Q-1.
    function automatic logic [CW-1:0] mod_q(input logic [9:0] a);
        logic [9:0] r;
        r = a % 10'(Q);
        return r[CW-1:0];
    endfunction

endpackage

// File: rtl/ntt_uart_loader_if.sv
// Loader-side signal bundle: serial input plus the committed vector and
// its status strobes. The loader is the slave, the surrounding top or
// bench the master.
interface ntt_uart_loader_if;
    import ntt_pkg::*;

    logic              uart_rx;
    logic [N*CW-1:0]   coeffs;
    logic              coeff_valid;
    logic              parse_err;
    logic              busy;

    modport slave (
        input  uart_rx,
        output coeffs,
        output coeff_valid,
        output parse_err,
        output busy
    );

    modport master (
        output uart_rx,
        input  coeffs,
        input  coeff_valid,
        input  parse_err,
        input  busy
    );

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, idle-line arming after reset,
// down-counting baud timer and a start/data/stop bit FSM. Emits one-cycle
// byte_valid or frame_err strobes, counterpart of the uart_tx module.
module uart_rx
    import ntt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_rx_data,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       r_sync;
    logic             r_rx_d;
    logic             r_armed;
    logic [CNT_W-1:0] r_arm_cnt;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_byte_valid;
    logic             r_frame_err;
    rx_state_t        r_state;
    logic             w_rx;

    assign w_rx = r_sync[1];

    // Bring the asynchronous line into clk; reset to idle-high so no false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            r_rx_d <= w_rx;
        end
    end

    // Arm on a full bit period of idle line, then run the bit FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RX_IDLE;
            r_armed      <= 1'b0;
            r_arm_cnt    <= BIT_LOAD;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            if (!r_armed) begin
                if (!w_rx)
                    r_arm_cnt <= BIT_LOAD;
                else if (r_arm_cnt == '0)
                    r_armed <= 1'b1;
                else
                    r_arm_cnt <= r_arm_cnt - 1'b1;
            end

            case (r_state)
                RX_IDLE: begin
                    // Edge rather than level, so a low stop bit cannot retrigger.
                    if (r_armed && r_rx_d && !w_rx) begin
                        r_baud_cnt <= HALF_LOAD;
                        r_state    <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_baud_cnt == '0) begin
                        if (!w_rx) begin
                            r_baud_cnt <= BIT_LOAD;
                            r_bit_idx  <= '0;
                            r_state    <= RX_DATA;
                        end else begin
                            r_state <= RX_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_baud_cnt == '0) begin
                        r_shift    <= {w_rx, r_shift[7:1]};
                        r_baud_cnt <= BIT_LOAD;
                        if (r_bit_idx == 3'd7)
                            r_state <= RX_STOP;
                        else
                            r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_baud_cnt == '0) begin
                        if (w_rx) begin
                            r_data       <= r_shift;
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= RX_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_rx_data    = r_data;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ntt_uart_loader.sv
// Receive front end for the 16-point NTT demo: parses one ASCII line of
// N decimal coefficients from uart_rx and commits them atomically.
// Build option NTT_LOADER_MODQ_EN: values >= Q are reduced mod Q instead
// of rejecting the line.
//
//  state     | meaning
//  P_IDLE    | waiting for the first digit of a line
//  P_NUM     | accumulating digits of coefficient idx
//  P_SEP     | idx values stored, between numbers
//  P_DISCARD | line rejected, dropping bytes until LF
module ntt_uart_loader
    import ntt_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic clk,
    input  logic rst,
    ntt_uart_loader_if.slave bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int IDX_W        = $clog2(N);

    logic [7:0]        w_rx_data;
    logic              w_byte_valid;
    logic              w_frame_err;
    logic              w_is_digit;
    logic              w_is_sep;
    logic              w_is_cr;
    logic              w_is_lf;
    logic [3:0]        w_digit;
    logic [9:0]        w_acc_next;
    logic [CW-1:0]     w_store_val;
    logic              w_store_bad;

    parse_state_t      r_state;
    logic [9:0]        r_acc;
    logic [1:0]        r_dcnt;
    logic [IDX_W:0]    r_idx;
    logic [CW-1:0]     r_stage [N];
    logic [N*CW-1:0]   r_coeffs;
    logic              r_coeff_valid;
    logic              r_parse_err;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (bus.uart_rx),
        .o_rx_data    (w_rx_data),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    assign w_is_digit = (w_rx_data >= ASC_0) && (w_rx_data <= ASC_0 + 8'd9);
    assign w_is_sep   = (w_rx_data == ASC_SP) || (w_rx_data == ASC_COMMA);
    assign w_is_cr    = (w_rx_data == ASC_CR);
    assign w_is_lf    = (w_rx_data == ASC_LF);
    // ASCII digits sit at 0x30..0x39, so the low nibble is the value.
    assign w_digit    = w_rx_data[3:0];
    assign w_acc_next = r_acc * 10'd10 + {6'd0, w_digit};

`ifdef NTT_LOADER_MODQ_EN
    assign w_store_val = mod_q(r_acc);
    assign w_store_bad = 1'b0;
`else
    assign w_store_val = r_acc[CW-1:0];
    assign w_store_bad = (r_acc >= 10'(Q));
`endif

    // Line parser: one decision per received byte, registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= P_IDLE;
            r_acc         <= '0;
            r_dcnt        <= '0;
            r_idx         <= '0;
            r_coeffs      <= '0;
            r_coeff_valid <= 1'b0;
            r_parse_err   <= 1'b0;
        end else begin
            r_coeff_valid <= 1'b0;
            r_parse_err   <= 1'b0;

            if (w_frame_err) begin
                r_parse_err <= 1'b1;
                r_state     <= P_DISCARD;
            end else if (w_byte_valid && !w_is_cr) begin
                case (r_state)
                    P_IDLE: begin
                        if (w_is_digit) begin
                            r_acc   <= {6'd0, w_digit};
                            r_dcnt  <= 2'd1;
                            r_idx   <= '0;
                            r_state <= P_NUM;
                        end else if (!(w_is_sep || w_is_lf)) begin
                            r_parse_err <= 1'b1;
                            r_state     <= P_DISCARD;
                        end
                    end
                    P_NUM: begin
                        if (w_is_digit) begin
                            if (r_dcnt < 2'd3) begin
                                r_acc  <= w_acc_next;
                                r_dcnt <= r_dcnt + 1'b1;
                            end else begin
                                r_parse_err <= 1'b1;
                                r_state     <= P_DISCARD;
                            end
                        end else if (w_is_sep) begin
                            if (w_store_bad) begin
                                r_parse_err <= 1'b1;
                                r_state     <= P_DISCARD;
                            end else begin
                                r_stage[r_idx[IDX_W-1:0]] <= w_store_val;
                                r_idx   <= r_idx + 1'b1;
                                r_state <= P_SEP;
                            end
                        end else if (w_is_lf) begin
                            // Last value goes straight into coeffs alongside the staged ones.
                            if (w_store_bad || r_idx != (IDX_W+1)'(N-1)) begin
                                r_parse_err <= 1'b1;
                            end else begin
                                for (int i = 0; i < N; i++)
                                    r_coeffs[i*CW +: CW] <= ((IDX_W+1)'(i) == r_idx) ?
                                                            w_store_val : r_stage[i];
                                r_coeff_valid <= 1'b1;
                            end
                            r_state <= P_IDLE;
                        end else begin
                            r_parse_err <= 1'b1;
                            r_state     <= P_DISCARD;
                        end
                    end
                    P_SEP: begin
                        if (w_is_digit) begin
                            if (r_idx == (IDX_W+1)'(N)) begin
                                r_parse_err <= 1'b1;
                                r_state     <= P_DISCARD;
                            end else begin
                                r_acc   <= {6'd0, w_digit};
                                r_dcnt  <= 2'd1;
                                r_state <= P_NUM;
                            end
                        end else if (w_is_lf) begin
                            if (r_idx == (IDX_W+1)'(N)) begin
                                for (int i = 0; i < N; i++)
                                    r_coeffs[i*CW +: CW] <= r_stage[i];
                                r_coeff_valid <= 1'b1;
                            end else begin
                                r_parse_err <= 1'b1;
                            end
                            r_state <= P_IDLE;
                        end else if (!w_is_sep) begin
                            r_parse_err <= 1'b1;
                            r_state     <= P_DISCARD;
                        end
                    end
                    P_DISCARD: begin
                        if (w_is_lf)
                            r_state <= P_IDLE;
                    end
                    default: r_state <= P_IDLE;
                endcase
            end
        end
    end

    assign bus.coeffs      = r_coeffs;
    assign bus.coeff_valid = r_coeff_valid;
    assign bus.parse_err   = r_parse_err;
    assign bus.busy        = (r_state != P_IDLE);

endmodule

// File: tb/tb_ntt_uart_loader.sv
// Directed bench for ntt_uart_loader at a shortened bit period.
module tb_ntt_uart_loader;
    import ntt_pkg::*;

    localparam int CLK_FREQ = 800;
    localparam int BAUD     = 100;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ntt_uart_loader_if bus();

    ntt_uart_loader #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;
    int n_busy_at_valid = 0;
    int n_glitch = 0;
    logic rst_q = 1'b1;
    logic [N*CW-1:0] prev_coeffs = '0;

    always @(posedge clk) rst_q <= rst;

    // Strobe monitor: counts pulses and flags protocol breaches.
    always @(negedge clk) begin
        if (bus.coeff_valid === 1'b1) n_valid++;
        if (bus.parse_err === 1'b1) n_err++;
        if (bus.coeff_valid === 1'b1 && bus.parse_err === 1'b1) n_both++;
        if (bus.coeff_valid === 1'b1 && bus.busy !== 1'b0) n_busy_at_valid++;
        if (!rst_q && bus.coeffs !== prev_coeffs && bus.coeff_valid !== 1'b1) n_glitch++;
        prev_coeffs = bus.coeffs;
    end

    function automatic logic [N*CW-1:0] pack_seq(input int base);
        logic [N*CW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(base + i);
        return v;
    endfunction

    function automatic string seq_str(input int base, input int count);
        string s;
        s = "";
        for (int i = 0; i < count; i++) begin
            if (i > 0) s = {s, " "};
            s = {s, $sformatf("%0d", base + i)};
        end
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        bus.uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.uart_rx = stop;
        repeat (CPB) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic test_reset;
        total_cnt++;
        if (bus.coeffs !== '0) $display("FAIL reset_coeffs: got %h want 0", bus.coeffs);
        else pass_cnt++;
        total_cnt++;
        if (bus.coeff_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.coeff_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.parse_err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.parse_err);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
        else pass_cnt++;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic test_basic;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_str(seq_str(1, 16));
        send_str("\n");
        total_cnt++;
        if (n_valid - v0 !== 1) $display("FAIL basic_valid: got %0d want 1", n_valid - v0);
        else pass_cnt++;
        total_cnt++;
        if (n_err - e0 !== 0) $display("FAIL basic_err: got %0d want 0", n_err - e0);
        else pass_cnt++;
        total_cnt++;
        if (bus.coeffs !== pack_seq(1)) $display("FAIL basic_coeffs: got %h want %h", bus.coeffs, pack_seq(1));
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL basic_busy: got %b want 0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_crlf;
        int v0;
        v0 = n_valid;
        send_str("96,0,0,0,0,0,0,0,0,0,0,0,0,0,0,5\r\n");
        total_cnt++;
        if (n_valid - v0 !== 1) $display("FAIL crlf_valid: got %0d want 1", n_valid - v0);
        else pass_cnt++;
        total_cnt++;
        if (bus.coeffs[0 +: CW] !== 7'd96) $display("FAIL crlf_c0: got %0d want 96", bus.coeffs[0 +: CW]);
        else pass_cnt++;
        total_cnt++;
        if (bus.coeffs[15*CW +: CW] !== 7'd5) $display("FAIL crlf_c15: got %0d want 5", bus.coeffs[15*CW +: CW]);
        else pass_cnt++;
        total_cnt++;
        if (bus.coeffs[7*CW +: CW] !== 7'd0) $display("FAIL crlf_c7: got %0d want 0", bus.coeffs[7*CW +: CW]);
        else pass_cnt++;
    endtask

    task automatic test_over_q;
        int v0, e0;
        logic [N*CW-1:0] exp_v;
        send_str(seq_str(1, 16));
        send_str("\n");
        v0 = n_valid; e0 = n_err;
        send_str("97 ");
        send_str(seq_str(2, 15));
        send_str("\n");
`ifdef NTT_LOADER_MODQ_EN
        exp_v = pack_seq(1);
        exp_v[0 +: CW] = '0;
        total_cnt++;
        if (n_valid - v0 !== 1) $display("FAIL overq_valid: got %0d want 1", n_valid - v0);
        else pass_cnt++;
        total_cnt++;
        if (n_err - e0 !== 0) $display("FAIL overq_err: got %0d want 0", n_err - e0);
        else pass_cnt++;
`else
        exp_v = pack_seq(1);
        total_cnt++;
        if (n_valid - v0 !== 0) $display("FAIL overq_valid: got %0d want 0", n_valid - v0);
        else pass_cnt++;
        total_cnt++;
        if (n_err - e0 !== 1) $display("FAIL overq_err: got %0d want 1", n_err - e0);
        else pass_cnt++;
`endif
        total_cnt++;
        if (bus.coeffs !== exp_v) $display("FAIL overq_coeffs: got %h want %h", bus.coeffs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_count;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_str(seq_str(1, 15));
        send_str("\n");
        total_cnt++;
        if (n_err - e0 !== 1 || n_valid - v0 !== 0)
            $display("FAIL count15: got err %0d valid %0d want 1 0", n_err - e0, n_valid - v0);
        else pass_cnt++;
        e0 = n_err;
        send_str(seq_str(1, 16));
        send_str(" ");
        total_cnt++;
        if (n_err - e0 !== 0) $display("FAIL count17_pre: got %0d want 0", n_err - e0);
        else pass_cnt++;
        send_str("1");
        total_cnt++;
        if (n_err - e0 !== 1) $display("FAIL count17_err: got %0d want 1", n_err - e0);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL count17_busy: got %b want 1", bus.busy);
        else pass_cnt++;
        send_str("7 8\n");
        total_cnt++;
        if (bus.busy !== 1'b0 || n_err - e0 !== 1)
            $display("FAIL count17_lf: got busy %b err %0d want 0 1", bus.busy, n_err - e0);
        else pass_cnt++;
        v0 = n_valid;
        send_str(seq_str(2, 16));
        send_str("\n");
        total_cnt++;
        if (n_valid - v0 !== 1) $display("FAIL count_recover: got %0d want 1", n_valid - v0);
        else pass_cnt++;
        total_cnt++;
        if (bus.coeffs !== pack_seq(2)) $display("FAIL count_coeffs: got %h want %h", bus.coeffs, pack_seq(2));
        else pass_cnt++;
    endtask

    task automatic test_illegal;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_str("1 2 ");
        total_cnt++;
        if (bus.busy !== 1'b1 || n_err - e0 !== 0)
            $display("FAIL illegal_pre: got busy %b err %0d want 1 0", bus.busy, n_err - e0);
        else pass_cnt++;
        send_str("x");
        total_cnt++;
        if (n_err - e0 !== 1) $display("FAIL illegal_x: got %0d want 1", n_err - e0);
        else pass_cnt++;
        send_str(" 3\n");
        e0 = n_err;
        send_str("123");
        total_cnt++;
        if (n_err - e0 !== 0) $display("FAIL digits3: got %0d want 0", n_err - e0);
        else pass_cnt++;
        send_str("4");
        total_cnt++;
        if (n_err - e0 !== 1) $display("FAIL digits4: got %0d want 1", n_err - e0);
        else pass_cnt++;
        send_str(" 5\n");
        total_cnt++;
        if (n_valid - v0 !== 0 || bus.coeffs !== pack_seq(2))
            $display("FAIL illegal_nocommit: got valid %0d coeffs %h want 0 %h", n_valid - v0, bus.coeffs, pack_seq(2));
        else pass_cnt++;
    endtask

    task automatic test_frame;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_str("1 2 ");
        send_byte(8'h33, 1'b0);
        total_cnt++;
        if (n_err - e0 !== 1) $display("FAIL frame_err: got %0d want 1", n_err - e0);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL frame_busy: got %b want 1", bus.busy);
        else pass_cnt++;
        send_str("\n");
        total_cnt++;
        if (bus.busy !== 1'b0 || n_valid - v0 !== 0)
            $display("FAIL frame_end: got busy %b valid %0d want 0 0", bus.busy, n_valid - v0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int v0;
        send_str("1 2 3");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (bus.coeffs !== '0 || bus.busy !== 1'b0 || bus.coeff_valid !== 1'b0 || bus.parse_err !== 1'b0)
            $display("FAIL rstmid_outputs: got coeffs %h busy %b valid %b err %b want all 0",
                     bus.coeffs, bus.busy, bus.coeff_valid, bus.parse_err);
        else pass_cnt++;
        repeat (CPB + 4) @(negedge clk);
        v0 = n_valid;
        send_str(seq_str(5, 16));
        send_str("\n");
        total_cnt++;
        if (n_valid - v0 !== 1) $display("FAIL rstmid_valid: got %0d want 1", n_valid - v0);
        else pass_cnt++;
        total_cnt++;
        if (bus.coeffs !== pack_seq(5)) $display("FAIL rstmid_coeffs: got %h want %h", bus.coeffs, pack_seq(5));
        else pass_cnt++;
    endtask

    task automatic test_protocol;
        total_cnt++;
        if (n_both !== 0) $display("FAIL strobes_overlap: got %0d want 0", n_both);
        else pass_cnt++;
        total_cnt++;
        if (n_busy_at_valid !== 0) $display("FAIL busy_at_valid: got %0d want 0", n_busy_at_valid);
        else pass_cnt++;
        total_cnt++;
        if (n_glitch !== 0) $display("FAIL coeffs_without_valid: got %0d want 0", n_glitch);
        else pass_cnt++;
    endtask

    initial begin
        bus.uart_rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_crlf();
        test_over_q();
        test_count();
        test_illegal();
        test_frame();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
